// File: rtl/ofmap_accum.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_accum
// Brief    : Output-feature-map accumulator. Every psum beat is merged into
//            the ofmap SRAM word at its address through a fixed read-add-write
//            pipeline: accept/read (S1) -> add (S2) -> write register. Beats
//            in flight to the same address are forwarded, so the final SRAM
//            contents match applying the beats one at a time.
// Options  : `define OFMAP_ACCUM_SAT_EN saturates each lane sum to the signed
//            range of a lane; without it lane sums wrap.
// Revision : 1.0 - initial release
// ============================================================================
module ofmap_accum #(
   parameter int MAC_COL        = 16,
   parameter int OFMAP_BITWIDTH = 32,
   parameter int OFMAP_ADDR_BIT = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                psum_valid_in,
   input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   psum_in,
   input  logic [OFMAP_ADDR_BIT-1:0]           psum_addr_in,
   input  logic                                psum_first_in,
   input  logic                                mac_done_in,
   output logic                                sram_rd_en_out,
   output logic [OFMAP_ADDR_BIT-1:0]           sram_rd_addr_out,
   input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   sram_rd_data_in,
   output logic                                sram_wr_en_out,
   output logic [OFMAP_ADDR_BIT-1:0]           sram_wr_addr_out,
   output logic [MAC_COL*OFMAP_BITWIDTH-1:0]   sram_wr_data_out,
   output logic                                busy_out,
   output logic                                done_out
);

   localparam int DATA_W = MAC_COL * OFMAP_BITWIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Where the S2 beat takes its accumulation base from.
   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,   // SRAM read data
      FWD_WR   = 2'd1,   // result of the beat directly ahead (now in write reg)
      FWD_HOLD = 2'd2    // result of the beat two ahead, captured on the way
   } fwd_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t                    state_q, state_d;
   logic                      done_q, done_d;

   logic                      s1_valid_q, s1_valid_d;
   logic                      s1_first_q, s1_first_d;
   logic [OFMAP_ADDR_BIT-1:0] s1_addr_q,  s1_addr_d;
   logic [DATA_W-1:0]         s1_data_q,  s1_data_d;

   logic                      s2_valid_q, s2_valid_d;
   logic                      s2_first_q, s2_first_d;
   logic [OFMAP_ADDR_BIT-1:0] s2_addr_q,  s2_addr_d;
   logic [DATA_W-1:0]         s2_data_q,  s2_data_d;
   fwd_t                      s2_fwd_q,   s2_fwd_d;
   logic [DATA_W-1:0]         hold_data_q, hold_data_d;

   logic                      wr_valid_q, wr_valid_d;
   logic [OFMAP_ADDR_BIT-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_W-1:0]         wr_data_q,  wr_data_d;

   logic                      beat_accept;
   logic                      pipe_empty;
   logic [DATA_W-1:0]         acc_base;
   logic [DATA_W-1:0]         acc_sum;

   // Beats arriving while draining belong to no layer and are dropped.
   assign beat_accept = psum_valid_in && (state_q != ST_DRAIN);
   assign pipe_empty  = !s1_valid_q && !s2_valid_q && !wr_valid_q;

   // ---------------------------------------------------------------------
   // Stage S1 capture and S1 -> S2 advance with hazard detection
   // ---------------------------------------------------------------------
   // Capture new beats into S1, shift S1 into S2 and pick the forward source.
   always_comb begin
      s1_valid_d  = beat_accept;
      s1_first_d  = s1_first_q;
      s1_addr_d   = s1_addr_q;
      s1_data_d   = s1_data_q;
      if (beat_accept) begin
         s1_first_d = psum_first_in;
         s1_addr_d  = psum_addr_in;
         s1_data_d  = psum_in;
      end

      s2_valid_d  = s1_valid_q;
      s2_first_d  = s1_first_q;
      s2_addr_d   = s1_addr_q;
      s2_data_d   = s1_data_q;
      s2_fwd_d    = FWD_NONE;
      hold_data_d = hold_data_q;

      // The beat in S2 now lands in the write register next cycle, which is
      // exactly when the S1 beat needs its base, so it is the newest source.
      // A match against the write register means that result is being
      // written to SRAM on the same edge our read samples it, so the read
      // data cannot be trusted; keep a private copy instead.
      if (s1_valid_q && s2_valid_q && (s2_addr_q == s1_addr_q)) begin
         s2_fwd_d = FWD_WR;
      end else if (s1_valid_q && wr_valid_q && (wr_addr_q == s1_addr_q)) begin
         s2_fwd_d    = FWD_HOLD;
         hold_data_d = wr_data_q;
      end
   end

   // ---------------------------------------------------------------------
   // Stage S2: lane-wise add against the selected base
   // ---------------------------------------------------------------------
   // Select the accumulation base for the beat in S2.
   always_comb begin
      acc_base = sram_rd_data_in;
      case (s2_fwd_q)
         FWD_WR:   acc_base = wr_data_q;
         FWD_HOLD: acc_base = hold_data_q;
         default:  acc_base = sram_rd_data_in;
      endcase
   end

`ifdef OFMAP_ACCUM_SAT_EN
   localparam logic [OFMAP_BITWIDTH-1:0] LANE_MAX = {1'b0, {(OFMAP_BITWIDTH-1){1'b1}}};
   localparam logic [OFMAP_BITWIDTH-1:0] LANE_MIN = {1'b1, {(OFMAP_BITWIDTH-1){1'b0}}};
`endif

   for (genvar i = 0; i < MAC_COL; i++) begin : g_lane
      logic [OFMAP_BITWIDTH-1:0] lane_psum;
      logic [OFMAP_BITWIDTH-1:0] lane_base;
      logic [OFMAP_BITWIDTH-1:0] lane_sum;

      assign lane_psum = s2_data_q[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];
      assign lane_base = acc_base[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];

`ifdef OFMAP_ACCUM_SAT_EN
      logic [OFMAP_BITWIDTH:0] sum_ext;

      assign sum_ext = {lane_psum[OFMAP_BITWIDTH-1], lane_psum}
                     + {lane_base[OFMAP_BITWIDTH-1], lane_base};

      // Clamp when the two top bits of the sign-extended sum disagree.
      always_comb begin
         lane_sum = sum_ext[OFMAP_BITWIDTH-1:0];
         if (sum_ext[OFMAP_BITWIDTH] != sum_ext[OFMAP_BITWIDTH-1]) begin
            lane_sum = sum_ext[OFMAP_BITWIDTH] ? LANE_MIN : LANE_MAX;
         end
      end
`else
      // Two's complement add wraps naturally at the lane width.
      assign lane_sum = lane_psum + lane_base;
`endif

      assign acc_sum[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] = lane_sum;
   end

   // ---------------------------------------------------------------------
   // Write register: one SRAM write per beat, two edges after accept
   // ---------------------------------------------------------------------
   // Load the write register from S2; first-tile beats overwrite.
   always_comb begin
      wr_valid_d = s2_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (s2_valid_q) begin
         wr_addr_d = s2_addr_q;
         wr_data_d = s2_first_q ? s2_data_q : acc_sum;
      end
   end

   // ---------------------------------------------------------------------
   // Layer control FSM
   // ---------------------------------------------------------------------
   // Next-state and done pulse for the IDLE/RUN/DRAIN layer sequencing.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mac_done_in) begin
               if (psum_valid_in || !pipe_empty) begin
                  state_d = ST_DRAIN;
               end else begin
                  done_d = 1'b1;
               end
            end else if (psum_valid_in) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mac_done_in) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // All pipeline and control flops; reset discards anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         done_q      <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_addr_q   <= '0;
         s1_data_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_addr_q   <= '0;
         s2_data_q   <= '0;
         s2_fwd_q    <= FWD_NONE;
         hold_data_q <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         s1_valid_q  <= s1_valid_d;
         s1_first_q  <= s1_first_d;
         s1_addr_q   <= s1_addr_d;
         s1_data_q   <= s1_data_d;
         s2_valid_q  <= s2_valid_d;
         s2_first_q  <= s2_first_d;
         s2_addr_q   <= s2_addr_d;
         s2_data_q   <= s2_data_d;
         s2_fwd_q    <= s2_fwd_d;
         hold_data_q <= hold_data_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs (all straight from flops)
   // ---------------------------------------------------------------------
   // The read is issued from S1 so its data returns while the beat is in S2.
   assign sram_rd_en_out   = s1_valid_q && !s1_first_q;
   assign sram_rd_addr_out = s1_addr_q;
   assign sram_wr_en_out   = wr_valid_q;
   assign sram_wr_addr_out = wr_addr_q;
   assign sram_wr_data_out = wr_data_q;
   assign busy_out         = (state_q != ST_IDLE);
   assign done_out         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ofmap_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_accum
// Brief    : Self-checking bench for ofmap_accum. A serial reference model
//            (one SRAM image updated beat by beat, a queue of pending writes)
//            predicts every output cycle by cycle; directed scenarios pin the
//            model with literal values, then randomized traffic follows.
//            Honours OFMAP_ACCUM_SAT_EN for the expected lane arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofmap_accum;

   localparam int LANES = 16;
   localparam int W     = 32;
   localparam int AW    = 10;
   localparam int DW    = LANES * W;
   localparam int DEPTH = 1 << AW;

   localparam longint LMAX = (64'sd1 <<< (W-1)) - 64'sd1;
   localparam longint LMIN = -(64'sd1 <<< (W-1));

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            psum_valid_in;
   logic [DW-1:0]   psum_in;
   logic [AW-1:0]   psum_addr_in;
   logic            psum_first_in;
   logic            mac_done_in;
   logic            sram_rd_en_out;
   logic [AW-1:0]   sram_rd_addr_out;
   logic [DW-1:0]   sram_rd_data_in;
   logic            sram_wr_en_out;
   logic [AW-1:0]   sram_wr_addr_out;
   logic [DW-1:0]   sram_wr_data_out;
   logic            busy_out;
   logic            done_out;

   ofmap_accum #(
      .MAC_COL        (LANES),
      .OFMAP_BITWIDTH (W),
      .OFMAP_ADDR_BIT (AW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .psum_valid_in    (psum_valid_in),
      .psum_in          (psum_in),
      .psum_addr_in     (psum_addr_in),
      .psum_first_in    (psum_first_in),
      .mac_done_in      (mac_done_in),
      .sram_rd_en_out   (sram_rd_en_out),
      .sram_rd_addr_out (sram_rd_addr_out),
      .sram_rd_data_in  (sram_rd_data_in),
      .sram_wr_en_out   (sram_wr_en_out),
      .sram_wr_addr_out (sram_wr_addr_out),
      .sram_wr_data_out (sram_wr_data_out),
      .busy_out         (busy_out),
      .done_out         (done_out)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Ofmap SRAM: 1-cycle read latency, old data on same-edge read/write
   // ---------------------------------------------------------------------
   logic [DW-1:0] mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      sram_rd_data_in = '0;
      forever begin
         @(posedge clk);
         if (sram_rd_en_out) sram_rd_data_in <= mem[sram_rd_addr_out];
         if (sram_wr_en_out) mem[sram_wr_addr_out] <= sram_wr_data_out;
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard counters and check helper
   // ---------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: serial SRAM image plus pending-write queue
   // ---------------------------------------------------------------------
   typedef struct {
      int            due;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic [DW-1:0] spec_mem  [DEPTH];   // value after every accepted beat
   logic [DW-1:0] committed [DEPTH];   // value after every issued write
   wr_t           wq[$];
   int            edge_no  = 0;
   int            mode     = M_IDLE;
   int            last_acc = -100;
   int            done_at  = -1;

   logic          exp_wr_en, exp_rd_en, exp_busy, exp_done;
   logic [AW-1:0] exp_wr_addr, exp_rd_addr;
   logic [DW-1:0] exp_wr_data;
   logic          chk_on = 1'b0;

   function automatic logic [DW-1:0] fill(input logic [W-1:0] v);
      return {LANES{v}};
   endfunction

   function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      longint        sa, sb, s;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         sa = $signed(a[i*W +: W]);
         sb = $signed(b[i*W +: W]);
         s  = sa + sb;
`ifdef OFMAP_ACCUM_SAT_EN
         if (s > LMAX) s = LMAX;
         else if (s < LMIN) s = LMIN;
`endif
         r[i*W +: W] = s[W-1:0];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < LANES; i++) d[i*W +: W] = $urandom();
      return d;
   endfunction

   // Advance the model by one rising edge with the inputs sampled there.
   task automatic model_edge(input logic v, input logic [AW-1:0] a, input logic f,
                             input logic [DW-1:0] d, input logic md, input logic r);
      logic          acc;
      logic [DW-1:0] nv;
      wr_t           w;
      edge_no++;
      exp_wr_en = 1'b0;
      exp_rd_en = 1'b0;
      exp_done  = 1'b0;
      if (r) begin
         wq.delete();
         spec_mem  = committed;
         mode      = M_IDLE;
         last_acc  = -100;
         done_at   = -1;
         exp_busy  = 1'b0;
         return;
      end
      if (wq.size() > 0 && wq[0].due == edge_no) begin
         w           = wq.pop_front();
         exp_wr_en   = 1'b1;
         exp_wr_addr = w.addr;
         exp_wr_data = w.data;
         committed[w.addr] = w.data;
      end
      acc = v && (mode != M_DRAIN);
      if (acc) begin
         nv          = f ? d : lane_add(spec_mem[a], d);
         spec_mem[a] = nv;
         w.due  = edge_no + 2;
         w.addr = a;
         w.data = nv;
         wq.push_back(w);
         exp_rd_en   = !f;
         exp_rd_addr = a;
         last_acc    = edge_no;
      end
      case (mode)
         M_IDLE: begin
            if (md) begin
               if (acc) begin
                  mode    = M_DRAIN;
                  done_at = last_acc + 4;
               end else begin
                  exp_done = 1'b1;
               end
            end else if (acc) begin
               mode = M_RUN;
            end
         end
         M_RUN: begin
            if (md) begin
               mode    = M_DRAIN;
               done_at = (edge_no + 1 > last_acc + 4) ? edge_no + 1 : last_acc + 4;
            end
         end
         default: begin
            if (edge_no == done_at) begin
               mode     = M_IDLE;
               exp_done = 1'b1;
            end
         end
      endcase
      exp_busy = (mode != M_IDLE);
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic f,
                       input logic [DW-1:0] d, input logic md, input logic r);
      rst           = r;
      psum_valid_in = v;
      psum_addr_in  = a;
      psum_first_in = f;
      psum_in       = d;
      mac_done_in   = md;
      @(posedge clk);
      model_edge(v, a, f, d, md, r);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // ---------------------------------------------------------------------
   // Cycle-by-cycle compare against the model
   // ---------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            check("wr_en", DW'(sram_wr_en_out), DW'(exp_wr_en));
            if (exp_wr_en) begin
               check("wr_addr", DW'(sram_wr_addr_out), DW'(exp_wr_addr));
               check("wr_data", sram_wr_data_out, exp_wr_data);
            end
            check("rd_en", DW'(sram_rd_en_out), DW'(exp_rd_en));
            if (exp_rd_en) check("rd_addr", DW'(sram_rd_addr_out), DW'(exp_rd_addr));
            check("busy", DW'(busy_out), DW'(exp_busy));
            check("done", DW'(done_out), DW'(exp_done));
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      logic [DW-1:0] exp_ovf;
      int            e0, pulses, done_edge;

      for (int i = 0; i < DEPTH; i++) begin
         spec_mem[i]  = '0;
         committed[i] = '0;
      end
      rst = 1'b1; psum_valid_in = 1'b0; psum_in = '0; psum_addr_in = '0;
      psum_first_in = 1'b0; mac_done_in = 1'b0;
      @(negedge clk);

      // Reset state
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      chk_on = 1'b1;
      check("rst_rd_en",   DW'(sram_rd_en_out), '0);
      check("rst_rd_addr", DW'(sram_rd_addr_out), '0);
      check("rst_wr_en",   DW'(sram_wr_en_out), '0);
      check("rst_wr_addr", DW'(sram_wr_addr_out), '0);
      check("rst_wr_data", sram_wr_data_out, '0);
      check("rst_busy",    DW'(busy_out), '0);
      check("rst_done",    DW'(done_out), '0);

      // Pin the model arithmetic
      check("model_add", lane_add(fill(32'd7), fill(32'd3)), fill(32'd10));
      check("model_neg", lane_add(fill(32'hFFFFFFFF), fill(32'hFFFFFFFF)), fill(32'hFFFFFFFE));

      // mac_done with nothing in flight: done on the next edge
      idle(1);
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check("idle_done", DW'(done_out), DW'(1));
      idle(1);
      check("idle_done_end", DW'(done_out), '0);

      // First pass: no read, write at k+2 with the psum itself
      step(1'b1, AW'(5), 1'b1, fill(32'd7), 1'b0, 1'b0);
      check("first_no_rd", DW'(sram_rd_en_out), '0);
      idle(2);
      check("first_wr_en",   DW'(sram_wr_en_out), DW'(1));
      check("first_wr_addr", DW'(sram_wr_addr_out), DW'(5));
      check("first_wr_data", sram_wr_data_out, fill(32'd7));
      idle(2);

      // Accumulate: read at k, write 7+3 at k+2
      step(1'b1, AW'(5), 1'b0, fill(32'd3), 1'b0, 1'b0);
      check("acc_rd_en",   DW'(sram_rd_en_out), DW'(1));
      check("acc_rd_addr", DW'(sram_rd_addr_out), DW'(5));
      idle(2);
      check("acc_wr_data", sram_wr_data_out, fill(32'd10));
      idle(2);
      check("acc_mem5", mem[5], fill(32'd10));

      // Back-to-back hazard on one address
      step(1'b1, AW'(9), 1'b1, fill(32'd1), 1'b0, 1'b0);
      step(1'b1, AW'(9), 1'b0, fill(32'd2), 1'b0, 1'b0);
      step(1'b1, AW'(9), 1'b0, fill(32'd4), 1'b0, 1'b0);
      idle(5);
      check("b2b_mem9", mem[9], fill(32'd7));

      // Hazard with a one-cycle gap
      step(1'b1, AW'(12), 1'b1, fill(32'd5), 1'b0, 1'b0);
      idle(1);
      step(1'b1, AW'(12), 1'b0, fill(32'd6), 1'b0, 1'b0);
      idle(5);
      check("gap_mem12", mem[12], fill(32'd11));

      // Overflow
`ifdef OFMAP_ACCUM_SAT_EN
      exp_ovf = fill(32'h7FFFFFFF);
`else
      exp_ovf = fill(32'h80000000);
`endif
      check("model_ovf", lane_add(fill(32'h7FFFFFFF), fill(32'd1)), exp_ovf);
      step(1'b1, AW'(20), 1'b1, fill(32'h7FFFFFFF), 1'b0, 1'b0);
      idle(4);
      step(1'b1, AW'(20), 1'b0, fill(32'd1), 1'b0, 1'b0);
      idle(5);
      check("ovf_mem20", mem[20], exp_ovf);

      // mac_done with the final beat; a beat during drain must be dropped
      step(1'b1, AW'(40), 1'b1, fill(32'd3), 1'b1, 1'b0);
      e0 = edge_no; pulses = 0; done_edge = -1;
      for (int j = 1; j <= 8; j++) begin
         if (j == 1) step(1'b1, AW'(41), 1'b1, fill(32'd9), 1'b0, 1'b0);
         else        idle(1);
         if (edge_no == e0 + 2) check("done_final_wr", DW'(sram_wr_en_out), DW'(1));
         if (edge_no == e0 + 3) check("done_busy_hi", DW'(busy_out), DW'(1));
         if (done_out) begin
            pulses++;
            done_edge = edge_no;
         end
      end
      check("done_edge",   DW'(done_edge - e0), DW'(4));
      check("done_pulses", DW'(pulses), DW'(1));
      check("done_busy_lo", DW'(busy_out), '0);
      check("drain_mem40", mem[40], fill(32'd3));
      check("drain_mem41", mem[41], '0);

      // Reset one edge after accept: no write afterwards
      step(1'b1, AW'(30), 1'b1, fill(32'h55), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      idle(4);
      check("rstmid_mem30", mem[30], '0);
      check("rstmid_busy", DW'(busy_out), '0);

      // Randomized traffic on a small address set to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         logic          v, f, md, r;
         logic [AW-1:0] a;
         v  = ($urandom_range(0, 3) != 0);
         a  = AW'($urandom_range(0, 5));
         f  = ($urandom_range(0, 4) == 0);
         md = ($urandom_range(0, 149) == 0);
         r  = ($urandom_range(0, 499) == 0);
         step(v, a, f, rand_data(), md, r);
      end
      if (mode != M_DRAIN) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      idle(12);
      check("end_busy", DW'(busy_out), '0);
      for (int i = 0; i < 64; i++) check("final_mem", mem[i], committed[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ofmap_accum.md
OFMAP_ACCUM -- requirements
Module: ofmap_accum

Interface
REQ-001 SHALL have parameter MAC_COL, default 16, number of psum lanes per beat.
REQ-002 SHALL have parameter OFMAP_BITWIDTH, default 32, signed width of each lane.
REQ-003 SHALL have parameter OFMAP_ADDR_BIT, default 10, ofmap SRAM address width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port psum_valid_in  in  1  psum beat present this cycle.
REQ-007 SHALL have port psum_in  in  MAC_COL*OFMAP_BITWIDTH  lane i at bits [i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH].
REQ-008 SHALL have port psum_addr_in  in  OFMAP_ADDR_BIT  ofmap word address of the beat.
REQ-009 SHALL have port psum_first_in  in  1  first weight tile: overwrite, not accumulate.
REQ-010 SHALL have port mac_done_in  in  1  one-cycle pulse: no further beats for this layer.
REQ-011 SHALL have port sram_rd_en_out  out  1  ofmap SRAM read strobe.
REQ-012 SHALL have port sram_rd_addr_out  out  OFMAP_ADDR_BIT  read address.
REQ-013 SHALL have port sram_rd_data_in  in  MAC_COL*OFMAP_BITWIDTH  read data, valid the cycle after the read edge.
REQ-014 SHALL have port sram_wr_en_out / sram_wr_addr_out / sram_wr_data_out  out  1 / OFMAP_ADDR_BIT / MAC_COL*OFMAP_BITWIDTH  write port.
REQ-015 SHALL have port busy_out  out  1  beats in flight or done pending.
REQ-016 SHALL have port done_out  out  1  one-cycle pulse after last write issued.

Function
REQ-017 SHALL accept a beat every cycle psum_valid_in=1; no backpressure.
REQ-018 SHALL, on the accept edge k, register beat into stage S1 and drive sram_rd_en_out=1 with sram_rd_addr_out=psum_addr_in from edge k, only if psum_first_in=0.
REQ-019 SHALL, at edge k+1, move S1 to S2; at edge k+2 drive sram_wr_en_out=1, sram_wr_addr_out=beat address, sram_wr_data_out=per-lane sum (or psum only when first) for exactly one cycle.
REQ-020 SHALL add lane-wise, signed, OFMAP_BITWIDTH result; no cross-lane carry.
REQ-021 SHALL forward: if the beat in S2 or the write register targets the same address as the beat in S1, use the newest in-flight result instead of sram_rd_data_in; final SRAM content SHALL equal serial execution.
REQ-022 SHALL issue writes in accept order; write latency fixed at 2 edges after accept, independent of hazards.
REQ-023 SHALL implement FSM IDLE -> RUN on first accepted beat; RUN -> DRAIN on mac_done_in; DRAIN -> IDLE when S1, S2 and write register are empty, pulsing done_out on that edge.
REQ-024 SHALL accept a beat coincident with mac_done_in and include it before done_out.
REQ-025 SHALL, on mac_done_in in IDLE with nothing in flight, pulse done_out on the next edge.
REQ-026 SHALL ignore psum_valid_in while in DRAIN.
REQ-027 SHALL drive busy_out=1 in RUN and DRAIN, 0 in IDLE.

Reset
REQ-028 SHALL, while rst=1 at an edge, clear all pipeline valids, return to IDLE, and drive sram_rd_en_out, sram_wr_en_out, busy_out, done_out to 0, addresses and data to 0.
REQ-029 SHALL discard in-flight beats on reset mid-operation; no write issued on or after the reset edge until new beats arrive.

Configuration
REQ-030 SHALL, with macro OFMAP_ACCUM_SAT_EN defined, saturate each lane sum to [-2^(OFMAP_BITWIDTH-1), 2^(OFMAP_BITWIDTH-1)-1]; without it, sums SHALL wrap modulo 2^OFMAP_BITWIDTH.

Verification
REQ-031 SHALL cover first pass: beat addr 5, first=1, lanes all 7 -> no read; write at edge k+2, addr 5, all lanes 7.
REQ-032 SHALL cover accumulate: SRAM addr 5 holds all 7, beat addr 5 first=0 lanes all 3 -> read at k, write all 10 at k+2.
REQ-033 SHALL cover back-to-back hazard: three consecutive beats addr 9, first=1 value 1 then first=0 values 2, 4 -> final SRAM addr 9 lanes all 7.
REQ-034 SHALL cover overflow: stored 0x7FFFFFFF + 1 -> 0x7FFFFFFF with OFMAP_ACCUM_SAT_EN, 0x80000000 without.
REQ-035 SHALL cover done: mac_done_in with final beat at same edge -> final write at +2, done_out one cycle, busy_out falls same edge.
REQ-036 SHALL cover reset mid-stream: rst at edge k+1 after accept at k -> no write at k+2, state IDLE, outputs zero.
